// File: rtl/accum_sched_pkg.sv
// Shared types and constants for the round-robin accumulator scheduler.
package accum_sched_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, HOLD1, HOLD2} state_t;
  localparam int ACC_LATENCY = 3;
  localparam int DEF_WIDTH   = 32;
endpackage

// File: rtl/accum_rr_sched_rr_arbiter.sv
// Combinational round-robin pick: first asserted req at or after ptr, modulo NREQ.
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic                    grant_valid,
  output logic [$clog2(NREQ)-1:0] grant_id
);
  localparam int IDW = $clog2(NREQ);

  int w_idx;

  // Scan from the farthest offset down so the nearest request overwrites last.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = '0;
    w_idx       = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_idx = int'(ptr) + k;
      if (w_idx >= NREQ) w_idx = w_idx - NREQ;
      if (req[w_idx]) begin
        grant_valid = 1'b1;
        grant_id    = IDW'(w_idx);
      end
    end
  end
endmodule

// File: rtl/accum_rr_sched.sv
// Shares one 3-cycle accumulator between NREQ requesters; all outputs are flops.
module accum_rr_sched
  import accum_sched_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNTW  = 16
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   req_value,
  output logic [NREQ-1:0]         ack,
  output logic                    acc_enable,
  output logic [WIDTH-1:0]        acc_value,
  output logic                    done,
  output logic [$clog2(NREQ)-1:0] done_id,
  output logic                    busy,
  output logic [CNTW-1:0]         issued
);
  localparam int IDW = $clog2(NREQ);

  state_t                     r_state, w_state_nxt;
  logic [IDW-1:0]             r_ptr, r_id, w_gid;
  logic                       w_gv, w_take;
  logic [NREQ-1:0]            w_ack_nxt;
  logic [NREQ-1:0][WIDTH-1:0] w_vals;

  logic [NREQ-1:0]  r_ack;
  logic             r_acc_enable, r_done, r_busy;
  logic [WIDTH-1:0] r_acc_value;
  logic [IDW-1:0]   r_done_id;
  logic [CNTW-1:0]  r_issued;

  assign w_vals = req_value;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req         (req),
    .ptr         (r_ptr),
    .grant_valid (w_gv),
    .grant_id    (w_gid)
  );

  always_ff @(posedge CLK) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_gv) w_state_nxt = ISSUE;
      ISSUE:   w_state_nxt = HOLD1;
      HOLD1:   w_state_nxt = HOLD2;
      HOLD2:   w_state_nxt = w_gv ? ISSUE : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Requests only count in IDLE and HOLD2; the accumulator is busy otherwise.
  always_comb begin
    w_take    = w_gv && (r_state == IDLE || r_state == HOLD2);
    w_ack_nxt = '0;
    if (w_take) w_ack_nxt[w_gid] = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_ack        <= '0;
      r_acc_enable <= 1'b0;
      r_acc_value  <= '0;
      r_done       <= 1'b0;
      r_done_id    <= '0;
      r_busy       <= 1'b0;
      r_issued     <= '0;
      r_ptr        <= '0;
      r_id         <= '0;
    end else begin
      r_ack        <= w_ack_nxt;
      r_acc_enable <= w_take;
      r_busy       <= (w_state_nxt != IDLE);
      r_done       <= (r_state == HOLD2);
      if (r_state == HOLD2) r_done_id <= r_id;
      if (w_take) begin
        r_id        <= w_gid;
        r_ptr       <= (int'(w_gid) == NREQ - 1) ? '0 : w_gid + 1'b1;
        r_acc_value <= w_vals[w_gid];
        r_issued    <= r_issued + 1'b1;
      end
    end
  end

  assign ack        = r_ack;
  assign acc_enable = r_acc_enable;
  assign acc_value  = r_acc_value;
  assign done       = r_done;
  assign done_id    = r_done_id;
  assign busy       = r_busy;
  assign issued     = r_issued;
endmodule

// File: tb/tb_accum_rr_sched.sv
// Directed bench for accum_rr_sched with a behavioural 3-cycle accumulator alongside.
module tb_accum_rr_sched;
  import accum_sched_pkg::*;

  localparam int NREQ = 4, WIDTH = 32, CNTW = 4;

  logic                  CLK, RST;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_value;
  logic [NREQ-1:0]       ack;
  logic                  acc_enable, done, busy;
  logic [WIDTH-1:0]      acc_value;
  logic [1:0]            done_id;
  logic [CNTW-1:0]       issued;

  int nerr = 0, nchk = 0;

  accum_rr_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .CNTW(CNTW)) dut (
    .CLK(CLK), .RST(RST), .req(req), .req_value(req_value), .ack(ack),
    .acc_enable(acc_enable), .acc_value(acc_value), .done(done),
    .done_id(done_id), .busy(busy), .issued(issued)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Accumulator stand-in: enable sampled at edge t, value added at edge t+2.
  logic [31:0] cnt;
  logic        en_d1, en_d2;
  int          ndone;
  always @(posedge CLK) begin
    if (RST) begin
      cnt <= '0; en_d1 <= 1'b0; en_d2 <= 1'b0; ndone <= 0;
    end else begin
      en_d1 <= acc_enable;
      en_d2 <= en_d1;
      if (en_d2) cnt <= cnt + acc_value;
      if (done)  ndone <= ndone + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    RST = 1'b1;
    req = '0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] exp3 [3];
    int n, last, sawg;
    exp3[0] = 4'b0010; exp3[1] = 4'b1000; exp3[2] = 4'b0010;
    req_value = '0;

    // reset state
    RST = 1'b1; req = '0;
    repeat (2) @(negedge CLK);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_en", 32'(acc_enable), 0);
    chk("rst_val", acc_value, 0);
    chk("rst_done", {30'd0, done_id} | 32'(done), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_issued", 32'(issued), 0);
    RST = 1'b0;

    // single requester 0, value 5
    @(negedge CLK);
    req_value = {32'd4, 32'd3, 32'd2, 32'd5};
    req = 4'b0001;
    @(negedge CLK);
    chk("t1_en", 32'(acc_enable), 1);
    chk("t1_ack", 32'(ack), 32'b0001);
    chk("t1_val0", acc_value, 5);
    chk("t1_busy", 32'(busy), 1);
    req = '0;
    @(negedge CLK);
    chk("t1_en_pulse", 32'(acc_enable), 0);
    chk("t1_val1", acc_value, 5);
    @(negedge CLK);
    chk("t1_val2", acc_value, 5);
    chk("t1_nodone", 32'(done), 0);
    @(negedge CLK);
    chk("t1_done", 32'(done), 1);
    chk("t1_done_id", 32'(done_id), 0);
    chk("t1_cnt", cnt, 5);
    @(negedge CLK);
    chk("t1_idle", 32'(busy), 0);
    chk("t1_ndone", ndone, 1);

    // all four held, eight operations
    do_reset();
    req_value = {32'd4, 32'd3, 32'd2, 32'd1};
    req = 4'b1111;
    n = 0; last = -1;
    for (int cyc = 0; cyc < 60 && n < 8; cyc++) begin
      @(negedge CLK);
      if (acc_enable) begin
        chk("t2_ack", 32'(ack), 32'(1) << (n % 4));
        if (n > 0) chk("t2_gap", cyc - last, 3);
        last = cyc;
        n++;
      end
    end
    req = '0;
    chk("t2_nops", n, 8);
    repeat (ACC_LATENCY + 1) @(negedge CLK);
    chk("t2_cnt", cnt, 20);
    chk("t2_issued", 32'(issued), 8);
    chk("t2_ndone", ndone, 8);
    chk("t2_idle", 32'(busy), 0);

    // requesters 1 and 3 from reset
    do_reset();
    req = 4'b1010;
    n = 0;
    for (int cyc = 0; cyc < 30 && n < 3; cyc++) begin
      @(negedge CLK);
      if (acc_enable) begin
        chk("t3_ack", 32'(ack), 32'(exp3[n]));
        n++;
      end
    end
    req = '0;
    chk("t3_nops", n, 3);
    repeat (ACC_LATENCY + 1) @(negedge CLK);
    chk("t3_idle", 32'(busy), 0);

    // reset during HOLD1
    do_reset();
    req_value = {32'd4, 32'd3, 32'd2, 32'd7};
    req = 4'b0001;
    @(negedge CLK);
    chk("t4_en", 32'(acc_enable), 1);
    req = '0;
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    chk("t4_ack", 32'(ack), 0);
    chk("t4_val", acc_value, 0);
    chk("t4_en0", 32'(acc_enable), 0);
    chk("t4_busy", 32'(busy), 0);
    chk("t4_issued", 32'(issued), 0);
    chk("t4_done", 32'(done), 0);
    RST = 1'b0;
    sawg = 0;
    repeat (4) begin
      @(negedge CLK);
      if (done) sawg = 1;
    end
    chk("t4_nodone", sawg, 0);
    chk("t4_ndone", ndone, 0);
    req = 4'b1001;
    @(negedge CLK);
    chk("t4_ptr0", 32'(ack), 32'b0001);
    req = '0;
    repeat (ACC_LATENCY + 1) @(negedge CLK);

    // counter wrap with CNTW=4, seventeen operations
    do_reset();
    req_value = {32'd4, 32'd3, 32'd2, 32'd1};
    req = 4'b0001;
    n = 0;
    for (int cyc = 0; cyc < 120 && n < 17; cyc++) begin
      @(negedge CLK);
      if (acc_enable) n++;
    end
    req = '0;
    chk("t5_nops", n, 17);
    repeat (ACC_LATENCY + 1) @(negedge CLK);
    chk("t5_issued", 32'(issued), 1);
    chk("t5_ndone", ndone, 17);
    chk("t5_cnt", cnt, 17);

    // req[2] pulsed only during HOLD1
    do_reset();
    req = 4'b0001;
    @(negedge CLK);
    chk("t6_en", 32'(acc_enable), 1);
    req = '0;
    @(negedge CLK);
    req = 4'b0100;
    @(negedge CLK);
    req = '0;
    sawg = 0;
    repeat (6) begin
      @(negedge CLK);
      if (acc_enable || ack != '0) sawg = 1;
    end
    chk("t6_nogrant", sawg, 0);
    chk("t6_idle", 32'(busy), 0);
    chk("t6_issued", 32'(issued), 1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
